// File: rtl/soc_rst_seq.sv
// soc_rst_seq: SoC reset sequencer for the always-on domain.
//
// Holds the SoC in reset until the PLL has been continuously locked for
// LOCK_STABLE_CYC cycles, then keeps reset asserted for HOLD_CYC more
// cycles before releasing it. A debounced reset button or a loss of PLL
// lock puts the SoC back into reset. The cause of the last reset and a
// saturating count of exits from the run state are reported.
//
// Ports:
//   clk         in   SoC clock; all state is in this domain
//   reset       in   asynchronous active-high reset
//   pll_locked  in   asynchronous PLL lock status
//   btn_rst_n   in   asynchronous raw reset button, active-low
//   soc_rst_n   out  registered active-low SoC reset (1 only in ST_RUN)
//   rst_cause   out  0 = power-on, 1 = PLL loss, 2 = button
//   reset_count out  saturating count of exits from ST_RUN
//   state_o     out  current state encoding
module soc_rst_seq #(
  parameter int LOCK_STABLE_CYC = 32,
  parameter int HOLD_CYC        = 64,
  parameter int DEBOUNCE_CYC    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       btn_rst_n,
  output logic       soc_rst_n,
  output logic [1:0] rst_cause,
  output logic [7:0] reset_count,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RUN       = 2'd2,
    ST_BTN_WAIT  = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_PLL = 2'd1;
  localparam logic [1:0] CAUSE_BTN = 2'd2;

  // One counter serves both WAIT_LOCK and HOLD; size it for the longer one.
  localparam int MAX_CYC = (LOCK_STABLE_CYC > HOLD_CYC) ? LOCK_STABLE_CYC : HOLD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // ---- Stage: input synchronizers ----
  logic [1:0] lock_sync;
  logic [1:0] btn_sync;
  logic       locked_s;
  logic       btn_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_sync <= 2'b00;
      btn_sync  <= 2'b00;
    end else begin
      lock_sync <= {lock_sync[0], pll_locked};
      btn_sync  <= {btn_sync[0], btn_rst_n};
    end
  end

  assign locked_s = lock_sync[1];
  assign btn_s    = btn_sync[1];

  // ---- Stage: button debounce ----
  // btn_db resets to "released" so the synchronizer's reset value of 0
  // does not look like a press; that 2-cycle mismatch is far shorter than
  // the debounce window.
  logic [DB_W-1:0] db_cnt;
  logic            btn_db;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt <= '0;
      btn_db <= 1'b1;
    end else if (btn_s != btn_db) begin
      if (db_cnt == DB_LAST) begin
        btn_db <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // ---- Stage: sequencer FSM ----
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       cause_nx;
  logic [7:0]       count_nx;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cause_nx = rst_cause;
    count_nx = reset_count;

    unique case (state)
      ST_WAIT_LOCK: begin
        if (!locked_s) begin
          cnt_nx = '0;
        end else if (cnt == LOCK_LAST) begin
          state_nx = btn_db ? ST_HOLD : ST_BTN_WAIT;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      ST_HOLD: begin
        // PLL loss is checked first so it wins over a simultaneous press.
        if (!locked_s) begin
          state_nx = ST_WAIT_LOCK;
          cause_nx = CAUSE_PLL;
        end else if (!btn_db) begin
          state_nx = ST_BTN_WAIT;
          cause_nx = CAUSE_BTN;
        end else if (cnt == HOLD_LAST) begin
          state_nx = ST_RUN;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_nx = ST_WAIT_LOCK;
          cause_nx = CAUSE_PLL;
        end else if (!btn_db) begin
          state_nx = ST_BTN_WAIT;
          cause_nx = CAUSE_BTN;
        end
      end
      ST_BTN_WAIT: begin
        if (!locked_s) begin
          state_nx = ST_WAIT_LOCK;
          cause_nx = CAUSE_PLL;
        end else if (btn_db) begin
          state_nx = ST_HOLD;
        end
      end
      default: state_nx = ST_WAIT_LOCK;
    endcase

    // Every state starts its count from zero.
    if (state_nx != state) begin
      cnt_nx = '0;
    end

    if ((state == ST_RUN) && (state_nx != ST_RUN)) begin
      count_nx = sat_inc8(reset_count);
    end
  end

  // soc_rst_n is registered from the next state so it changes on the same
  // edge as the state register and has no combinational input path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_WAIT_LOCK;
      cnt         <= '0;
      soc_rst_n   <= 1'b0;
      rst_cause   <= 2'd0;
      reset_count <= 8'd0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      soc_rst_n   <= (state_nx == ST_RUN);
      rst_cause   <= cause_nx;
      reset_count <= count_nx;
    end
  end

  assign state_o = state;

endmodule

// File: doc/soc_rst_seq.md
SOC_RST_SEQ -- requirements
Module: soc_rst_seq

Interface
REQ-001 SHALL have parameter LOCK_STABLE_CYC, default 32: consecutive synchronized pll_locked-high cycles required before leaving ST_WAIT_LOCK.
REQ-002 SHALL have parameter HOLD_CYC, default 64: cycles SoC reset is held after lock or button release.
REQ-003 SHALL have parameter DEBOUNCE_CYC, default 16: cycles a synchronized button level must persist before the debounced value changes.
REQ-004 SHALL have port clk, input, 1: single clock for all state (16 MHz SoC clock domain).
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port pll_locked, input, 1: asynchronous PLL lock status.
REQ-007 SHALL have port btn_rst_n, input, 1: asynchronous raw reset button, active-low (pressed = 0).
REQ-008 SHALL have port soc_rst_n, output, 1: active-low reset to the SoC always-on reset pad input.
REQ-009 SHALL have port rst_cause, output, 2: cause of last SoC reset (0 = power-on, 1 = PLL loss, 2 = button, 3 unused).
REQ-010 SHALL have port reset_count, output, 8: saturating count of exits from ST_RUN.
REQ-011 SHALL have port state_o, output, 2: current state encoding.

Function
REQ-012 SHALL synchronize pll_locked and btn_rst_n each through a 2-flop synchronizer; the second-stage outputs are locked_s and btn_s.
REQ-013 SHALL debounce btn_s: btn_db changes only after btn_s differs from btn_db for DEBOUNCE_CYC consecutive cycles; any return to equality clears the debounce counter.
REQ-014 SHALL implement states ST_WAIT_LOCK = 0, ST_HOLD = 1, ST_RUN = 2, ST_BTN_WAIT = 3, with state_o equal to the state register.
REQ-015 ST_WAIT_LOCK SHALL count consecutive cycles with locked_s = 1 and clear the count on any locked_s = 0.
REQ-016 ST_WAIT_LOCK, after LOCK_STABLE_CYC consecutive counted cycles: SHALL go to ST_BTN_WAIT if btn_db = 0, else to ST_HOLD.
REQ-017 ST_HOLD SHALL count HOLD_CYC cycles and then go to ST_RUN.
REQ-018 ST_RUN SHALL be held until an exit event.
REQ-019 ST_BTN_WAIT SHALL go to ST_HOLD on btn_db = 1.
REQ-020 Every state counter SHALL clear on state entry.
REQ-021 In ST_HOLD, ST_RUN and ST_BTN_WAIT, locked_s = 0 SHALL force the next state to ST_WAIT_LOCK and set rst_cause = 1.
REQ-022 In ST_HOLD or ST_RUN, btn_db = 0 with locked_s = 1 SHALL force the next state to ST_BTN_WAIT and set rst_cause = 2.
REQ-023 When locked_s = 0 and btn_db = 0 occur in the same cycle, PLL loss SHALL take priority (ST_WAIT_LOCK, rst_cause = 1).
REQ-024 soc_rst_n SHALL be a register equal to 1 exactly while the state register is ST_RUN, updated on the same edge as the state, with no combinational path from inputs.
REQ-025 reset_count SHALL increment by 1 on each transition out of ST_RUN and saturate at 255.
REQ-026 rst_cause SHALL hold its value until the next reset event.
REQ-027 Latency from a pll_locked fall to soc_rst_n low SHALL be 3 rising edges.
REQ-028 A button press shorter than DEBOUNCE_CYC cycles SHALL have no effect.

Reset
REQ-029 On reset = 1, all flops SHALL clear immediately, regardless of clk: state = ST_WAIT_LOCK, soc_rst_n = 0, rst_cause = 0, reset_count = 0, all counters = 0, synchronizer flops = 0, btn_db = 1.
REQ-030 Reset asserted in any state mid-operation SHALL abort the sequence; after release the full WAIT_LOCK/HOLD sequence repeats.

Verification
REQ-031 Power-up: release reset with pll_locked = 1 and btn_rst_n = 1 held -> soc_rst_n rises after rising edge 98 (2 sync + 32 lock + 64 hold), rst_cause = 0, reset_count = 0.
REQ-032 Lock glitch: pll_locked low for 1 cycle at lock count 20 in ST_WAIT_LOCK -> lock count restarts; soc_rst_n rise delayed by at least 21 cycles versus REQ-031.
REQ-033 Button:
- btn_rst_n low for 10 cycles in ST_RUN -> soc_rst_n stays 1.
- btn_rst_n low for 40 cycles in ST_RUN -> soc_rst_n falls 19 edges after the press, rst_cause = 2, reset_count = 1.
- After release: 2 + 16 cycles debounce, then 64 hold cycles -> soc_rst_n = 1.
REQ-034 Simultaneous events: pll_locked falls on the same edge btn_db goes 0 in ST_RUN -> state_o = 0, rst_cause = 1, reset_count increments once.
REQ-035 Reset mid-ST_HOLD: assert reset asynchronously -> soc_rst_n = 0, state_o = 0, reset_count = 0 before the next clk edge.
REQ-036 Saturation: 260 PLL-loss cycles from ST_RUN -> reset_count = 255 and no wrap.
